// File: rtl/pll_divider_prog.sv
// rtl/pll_divider_prog.sv - run-time programmable clock divider / tick generator
//
// Purpose:
//   Divides clk_in by a programmable divisor D to produce either a 50% duty
//   square wave (toggle mode, period 2*D) or a one-cycle strobe every D
//   cycles (pulse mode). A new divisor/mode is accepted through a
//   valid/ready handshake, held as pending, and applied only at a period
//   boundary (wrap), while the counter is stopped (en=0) or on sync_clr,
//   so clk_out never glitches mid-period.
//
// Optional feature:
//   PLL_DIVIDER_PERIOD_COUNT_EN - adds period_cnt, a saturating 16-bit count
//   of wraps, cleared by reset and sync_clr (not by a load).
//
// Ports:
//   clk_in      in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   en          in   count enable
//   sync_clr    in   phase restart request (one cycle)
//   div_in      in   requested divisor (0 is clamped to 1)
//   div_mode    in   requested mode: 0 toggle, 1 pulse
//   div_valid   in   load request
//   div_ready   out  divider can accept a load
//   clk_out     out  divided clock or strobe
//   tick        out  one-cycle pulse on every counter wrap
//   cfg_pending out  accepted setting waiting to be applied
//   period_cnt  out  wrap count (only with PLL_DIVIDER_PERIOD_COUNT_EN)

module pll_divider_prog #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = 12588,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_mode,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending
`ifdef PLL_DIVIDER_PERIOD_COUNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_mode;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_mode;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_div_ready;
  logic             r_cfg_pending;

  logic             w_last;
  logic             w_wrap;
  logic             w_apply;
  logic             w_mode_chg;
  logic [CNT_W-1:0] w_div_clamped;

  // D is never 0, so D-1 cannot underflow.
  assign w_last        = (r_cnt == (r_div - ONE));
  assign w_wrap        = en && w_last;
  // Pending setting lands at a period boundary or whenever counting is stopped.
  assign w_apply       = (r_state == ST_PEND) && (w_wrap || !en);
  assign w_mode_chg    = (r_pend_mode != r_mode);
  assign w_div_clamped = (div_in == '0) ? ONE : div_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_div         <= DEF_DIV;
      r_mode        <= DEFAULT_MODE;
      r_pend_div    <= '0;
      r_pend_mode   <= 1'b0;
      r_clk_out     <= 1'b0;
      r_tick        <= 1'b0;
      r_div_ready   <= 1'b1;
      r_cfg_pending <= 1'b0;
    end else if (sync_clr) begin
      // Phase restart; a simultaneous handshake is deliberately not accepted.
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      if (r_state == ST_PEND) begin
        r_div         <= r_pend_div;
        r_mode        <= r_pend_mode;
        r_state       <= ST_IDLE;
        r_div_ready   <= 1'b1;
        r_cfg_pending <= 1'b0;
      end
    end else begin
      // Counting path: the completing period always uses the current D/mode.
      if (en) begin
        if (w_last) begin
          r_cnt     <= '0;
          r_tick    <= 1'b1;
          r_clk_out <= r_mode ? 1'b1 : ~r_clk_out;
        end else begin
          r_cnt     <= r_cnt + ONE;
          r_tick    <= 1'b0;
          r_clk_out <= r_mode ? 1'b0 : r_clk_out;
        end
      end else begin
        r_tick <= 1'b0;
        if (r_mode) begin
          r_clk_out <= 1'b0;
        end
      end

      // Load handshake; later assignments here override the counting path.
      case (r_state)
        ST_IDLE: begin
          if (div_valid) begin
            r_pend_div    <= w_div_clamped;
            r_pend_mode   <= div_mode;
            r_state       <= ST_PEND;
            r_div_ready   <= 1'b0;
            r_cfg_pending <= 1'b1;
          end
        end
        ST_PEND: begin
          if (w_apply) begin
            r_div         <= r_pend_div;
            r_mode        <= r_pend_mode;
            r_state       <= ST_IDLE;
            r_div_ready   <= 1'b1;
            r_cfg_pending <= 1'b0;
            if (w_mode_chg) begin
              // Mode switch restarts the phase with the output low.
              r_clk_out <= 1'b0;
              r_cnt     <= '0;
            end else if (!en && (r_cnt >= r_pend_div)) begin
              // A held count beyond the new last value would never wrap.
              r_cnt <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PLL_DIVIDER_PERIOD_COUNT_EN
  logic [15:0] r_period_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_period_cnt <= 16'h0000;
    end else if (sync_clr) begin
      r_period_cnt <= 16'h0000;
    end else if (w_wrap && (r_period_cnt != 16'hFFFF)) begin
      r_period_cnt <= r_period_cnt + 16'h0001;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

  assign div_ready   = r_div_ready;
  assign clk_out     = r_clk_out;
  assign tick        = r_tick;
  assign cfg_pending = r_cfg_pending;

endmodule

// File: tb/tb_pll_divider_prog.sv
// tb/tb_pll_divider_prog.sv - scoreboard bench for pll_divider_prog

module tb_pll_divider_prog;

  localparam int CNT_W    = 8;
  localparam int DEF_DIV  = 3;
  localparam bit DEF_MODE = 1'b0;

  logic             clk_in    = 1'b0;
  logic             rst_n     = 1'b0;
  logic             en        = 1'b0;
  logic             sync_clr  = 1'b0;
  logic [CNT_W-1:0] div_in    = '0;
  logic             div_mode  = 1'b0;
  logic             div_valid = 1'b0;
  logic             div_ready;
  logic             clk_out;
  logic             tick;
  logic             cfg_pending;
`ifdef PLL_DIVIDER_PERIOD_COUNT_EN
  logic [15:0]      period_cnt;
`endif

  pll_divider_prog #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_DIV),
    .DEFAULT_MODE(DEF_MODE)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .sync_clr   (sync_clr),
    .div_in     (div_in),
    .div_mode   (div_mode),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .clk_out    (clk_out),
    .tick       (tick),
    .cfg_pending(cfg_pending)
`ifdef PLL_DIVIDER_PERIOD_COUNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        clk_out;
    logic        tick;
    logic        ready;
    logic        pend;
    logic [15:0] pc;
  } obs_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: position within the current period, active divisor,
  // output level, and a single-entry pending slot.
  int m_pos, m_d, m_pdiv, m_pc;
  bit m_mode, m_pmode, m_out, m_tick, m_pend;

  task automatic model_step(input bit r, input bit e, input bit s,
                            input int din, input bit dm, input bit dv);
    bit wrap;
    bit was_pend;
    if (!r) begin
      m_pos = 0; m_d = DEF_DIV; m_mode = DEF_MODE; m_out = 0; m_tick = 0;
      m_pend = 0; m_pdiv = 0; m_pmode = 0; m_pc = 0;
    end else if (s) begin
      m_pos = 0; m_out = 0; m_tick = 0; m_pc = 0;
      if (m_pend) begin
        m_d = m_pdiv; m_mode = m_pmode; m_pend = 0;
      end
    end else begin
      was_pend = m_pend;
      wrap = e && (m_pos + 1 == m_d);
      m_tick = wrap;
      if (wrap) begin
        m_pos = 0;
        m_out = m_mode ? 1'b1 : !m_out;
        if (m_pc < 65535) m_pc = m_pc + 1;
      end else begin
        if (e) m_pos = m_pos + 1;
        if (m_mode) m_out = 0;
      end
      if (was_pend && (wrap || !e)) begin
        if (m_pmode != m_mode) begin
          m_out = 0;
          m_pos = 0;
        end
        m_d = m_pdiv; m_mode = m_pmode; m_pend = 0;
        if (m_pos >= m_d) m_pos = 0;
      end else if (!was_pend && dv) begin
        m_pdiv = (din == 0) ? 1 : din;
        m_pmode = dm;
        m_pend = 1;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit s,
                       input int din, input bit dm, input bit dv);
    obs_t x;
    @(negedge clk_in);
    rst_n = r; en = e; sync_clr = s; div_in = din[CNT_W-1:0];
    div_mode = dm; div_valid = dv;
    model_step(r, e, s, din, dm, dv);
    x.clk_out = m_out;
    x.tick    = m_tick;
    x.ready   = !m_pend;
    x.pend    = m_pend;
`ifdef PLL_DIVIDER_PERIOD_COUNT_EN
    x.pc      = 16'(m_pc);
`else
    x.pc      = 16'h0000;
`endif
    sb_q.push_back(x);
  endtask

  task automatic run(input int n, input bit e);
    for (int k = 0; k < n; k++) cycle(1, e, 0, 0, 0, 0);
  endtask

  task automatic run_to_pos(input int p);
    for (int k = 0; k < 300 && m_pos != p; k++) cycle(1, 1, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are registered and present every cycle.
  obs_t exp_v, act_v;
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        act_v.clk_out = clk_out;
        act_v.tick    = tick;
        act_v.ready   = div_ready;
        act_v.pend    = cfg_pending;
`ifdef PLL_DIVIDER_PERIOD_COUNT_EN
        act_v.pc      = period_cnt;
`else
        act_v.pc      = 16'h0000;
`endif
        n_checks++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL outs @%0t: got clk_out=%b tick=%b ready=%b pend=%b pc=%0d, exp clk_out=%b tick=%b ready=%b pend=%b pc=%0d",
                      $time, act_v.clk_out, act_v.tick, act_v.ready, act_v.pend, act_v.pc,
                      exp_v.clk_out, exp_v.tick, exp_v.ready, exp_v.pend, exp_v.pc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    // 1: reset defaults, then count from edge 1
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    run(12, 1);

    // 2: reload to 5 mid-period in toggle mode
    run_to_pos(1);
    cycle(1, 1, 0, 5, 0, 1);
    run(22, 1);

    // 3: pulse mode with D=4, then zero clamp to D=1
    cycle(1, 1, 0, 4, 1, 1);
    run(18, 1);
    cycle(1, 1, 0, 0, 1, 1);
    run(8, 1);

    // 4: enable gating at position 1 with D=3 toggle
    cycle(1, 1, 0, 3, 0, 1);
    run(6, 1);
    run_to_pos(1);
    run(10, 0);
    run(8, 1);

    // 5: sync_clr while a load of 7 is pending
    run_to_pos(0);
    cycle(1, 1, 0, 7, 0, 1);
    cycle(1, 1, 1, 0, 0, 0);
    run(16, 1);

    // 6: reset with a load pending, then four wraps at the default divisor
    run_to_pos(1);
    cycle(1, 1, 0, 5, 1, 1);
    cycle(0, 1, 0, 0, 0, 0);
    run(14, 1);

    // handshake colliding with a wrap edge
    run_to_pos(DEF_DIV - 1);
    cycle(1, 1, 0, 2, 0, 1);
    run(8, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 249) != 0),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 59) == 0),
            int'($urandom_range(0, 9)),
            bit'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0));
    end
    run(10, 1);

    @(posedge clk_in);
    #3;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d entries left, required 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_divider_prog.md
Name: pll_divider_prog

Overview:
- Parametrised, run-time programmable clock divider/tick generator. Successor to the fixed 50 kHz -> 1 kHz divider.
- Derives a low-rate clock or strobe from the system clock.
- Divisor and output mode can be reloaded through a valid/ready handshake. A new setting takes effect only at a period boundary, so clk_out never glitches.
- Sits between the board clock and the slow-rate consumers (display scan, debounce, sampling).

Parameters:
- CNT_W, 16: width of counter, divisor register and div_in.
- DEFAULT_DIV, 12588: divisor loaded at reset. Must be 1..2^CNT_W-1.
- DEFAULT_MODE, 0: output mode at reset. 0 = toggle (50% duty square wave), 1 = pulse (one-cycle strobe).

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  count enable.
- sync_clr  input  1  phase restart: one-cycle request to realign output phase.
- div_in  input  CNT_W  requested divisor.
- div_mode  input  1  requested mode, loaded together with div_in.
- div_valid  input  1  load request.
- div_ready  output  1  divider can accept a load.
- clk_out  output  1  divided clock (toggle mode) or strobe (pulse mode).
- tick  output  1  one-cycle pulse on every counter wrap.
- cfg_pending  output  1  an accepted setting is waiting to be applied.

Behaviour:
- All outputs are registered. Priority order: rst_n low > sync_clr > wrap/load > count.
- Reset (rst_n=0 at an edge):
  - cnt=0, D=DEFAULT_DIV, mode_r=DEFAULT_MODE.
  - clk_out=0, tick=0, div_ready=1, cfg_pending=0.
  - Pending registers cleared.
- Counting (en=1):
  - cnt increments each cycle.
  - Wrap occurs when cnt==D-1. At the wrap edge: cnt<=0 and tick<=1 for exactly one cycle.
  - Toggle mode: clk_out<=~clk_out at each wrap, so the output period is 2*D cycles.
  - Pulse mode: clk_out<=1 at the wrap edge and 0 otherwise; clk_out equals tick.
- D=1:
  - Wrap occurs every cycle.
  - Toggle mode gives clk_out = clk_in/2.
  - Pulse mode holds tick and clk_out constantly high.
- en=0:
  - cnt holds.
  - tick<=0.
  - Pulse mode: clk_out<=0. Toggle mode: clk_out holds its level.
  - A pending setting is applied on the first en=0 cycle.
- Load handshake, two states:
  - IDLE: div_ready=1, cfg_pending=0. div_valid&&div_ready at an edge captures div_in/div_mode into pend_div/pend_mode and moves to PEND.
  - PEND: div_ready=0, cfg_pending=1. Further div_valid is ignored; the requester must hold or retry.
  - PEND -> IDLE on the first of: a wrap edge, an edge with en=0, or sync_clr. On that transition D<=pend_div and mode_r<=pend_mode. At a wrap, the completing period uses the old D; the next period uses the new D.
  - div_in==0 is accepted and clamped to 1.
- Mode change at apply:
  - clk_out<=0 and cnt<=0.
  - Toggle mode restarts low.
- sync_clr=1 (rst_n high):
  - cnt<=0, clk_out<=0, tick<=0.
  - A pending setting is applied in the same edge.
  - A load handshake in the same edge is not accepted.
- Simultaneous wrap and handshake in IDLE:
  - The wrap completes with the old D.
  - The new value is captured into PEND and applied at the next wrap.
- Reset mid-period or with a load pending: the pending load is discarded and defaults are restored.
- Width: cnt is CNT_W bits and compares against D-1 with no overflow; cnt never exceeds D-1.

Optional Feature:
- Macro: PLL_DIVIDER_PERIOD_COUNT_EN.
- With the macro defined:
  - Adds output period_cnt [15:0], cleared by reset and by sync_clr.
  - Increments by 1 on each wrap and saturates at 16'hFFFF.
  - Not cleared by a load.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset defaults: CNT_W=8, DEFAULT_DIV=3, DEFAULT_MODE=0. Release rst_n, then en=1 from edge 1 -> tick high after edges 3, 6, 9. clk_out rises after edge 3, falls after edge 6, giving period 6.
2. Reload at wrap: D=3, toggle mode. Assert div_valid with div_in=5, accepted mid-period -> div_ready=0 and cfg_pending=1 until the next wrap. Subsequent wraps are 5 cycles apart.
3. Pulse mode and zero clamp: load div_in=4 with div_mode=1 -> clk_out high 1 cycle in every 4. Then load div_in=0 -> D=1, clk_out and tick constantly high.
4. Enable gating: toggle mode with D=3; drop en at cnt=1 for 10 cycles -> cnt holds at 1, clk_out holds, tick stays 0. Wrap occurs 2 cycles after en returns.
5. sync_clr during PEND with div_in=7 -> next edge: cnt=0, clk_out=0, D=7, div_ready=1. First tick 7 cycles later.
6. Reset mid-operation with a load pending -> D=DEFAULT_DIV, cfg_pending=0, clk_out=0. With PLL_DIVIDER_PERIOD_COUNT_EN: period_cnt=0, and it reads 4 after 4 wraps.
